// File: rtl/commit_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : commit_unit_if
// Brief    : Scoreboard-head / register-file / flush bundle for commit_unit.
// Revision : 1.0 - initial release
// ============================================================================
interface commit_unit_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 32
);
    logic              is_empty;
    logic              head_ready;
    logic [DATA_W-1:0] head_instr;
    logic [DATA_W-1:0] head_value;
    logic              flush_req;
    logic [DATA_W-1:0] flush_tag;

    logic              start_head;
    logic              committing_instr;
    logic              flushing_instr;
    logic [DATA_W-1:0] instr_to_flush;
    logic              rf_we;
    logic [REG_W-1:0]  rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [CNT_W-1:0]  commit_count;
    logic              busy;

    // Environment view: scoreboard head, branch unit and register file.
    modport master (
        output is_empty, head_ready, head_instr, head_value, flush_req, flush_tag,
        input  start_head, committing_instr, flushing_instr, instr_to_flush,
        input  rf_we, rf_waddr, rf_wdata, commit_count, busy
    );

    // Commit-unit view.
    modport slave (
        input  is_empty, head_ready, head_instr, head_value, flush_req, flush_tag,
        output start_head, committing_instr, flushing_instr, instr_to_flush,
        output rf_we, rf_waddr, rf_wdata, commit_count, busy
    );
endinterface
`default_nettype wire

// File: rtl/commit_unit.sv
`default_nettype none
// ============================================================================
// Module   : commit_unit
// Brief    : In-order retirement stage: pops the scoreboard head, writes the
//            register file, counts retirements and forwards flush requests.
// Revision : 1.0 - initial release
// ============================================================================
module commit_unit #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 32
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    commit_unit_if.slave sb
);

    localparam int c_RD_LSB = 7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COMMIT = 2'd1,
        ST_FLUSH  = 2'd2,
        ST_SETTLE = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic              r_pend;
    logic              w_pend_nxt;
    logic [DATA_W-1:0] r_tag;
    logic [DATA_W-1:0] w_tag_nxt;

    logic              r_start;
    logic              w_start_nxt;
    logic              r_flush;
    logic              w_flush_nxt;
    logic [DATA_W-1:0] r_itf;
    logic [DATA_W-1:0] w_itf_nxt;
    logic              r_we;
    logic              w_we_nxt;
    logic [REG_W-1:0]  r_waddr;
    logic [REG_W-1:0]  w_waddr_nxt;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] w_wdata_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              r_busy;

    logic [REG_W-1:0]  w_rd;
    logic [DATA_W-1:0] w_flush_id;

    assign w_rd       = sb.head_instr[c_RD_LSB +: REG_W];
    // A request arriving in IDLE is newer than any pending one.
    assign w_flush_id = sb.flush_req ? sb.flush_tag : r_tag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_pend  <= 1'b0;
            r_tag   <= '0;
            r_start <= 1'b0;
            r_flush <= 1'b0;
            r_itf   <= '0;
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pend  <= w_pend_nxt;
            r_tag   <= w_tag_nxt;
            r_start <= w_start_nxt;
            r_flush <= w_flush_nxt;
            r_itf   <= w_itf_nxt;
            r_we    <= w_we_nxt;
            r_waddr <= w_waddr_nxt;
            r_wdata <= w_wdata_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
        end
    end

    // Strobes are computed for the state being entered so every output is a
    // plain register that is high exactly while the FSM sits in that state.
    always_comb begin
        w_state_nxt = r_state;
        w_pend_nxt  = r_pend;
        w_tag_nxt   = r_tag;
        w_start_nxt = 1'b0;
        w_flush_nxt = 1'b0;
        w_itf_nxt   = '0;
        w_we_nxt    = 1'b0;
        w_waddr_nxt = '0;
        w_wdata_nxt = '0;
        w_cnt_nxt   = r_cnt;

        case (r_state)
            ST_IDLE: begin
                if (sb.flush_req || r_pend) begin
                    w_state_nxt = ST_FLUSH;
                    w_flush_nxt = 1'b1;
                    w_itf_nxt   = w_flush_id;
                    w_tag_nxt   = w_flush_id;
                    w_pend_nxt  = 1'b0;
                end else if (!sb.is_empty && sb.head_ready) begin
                    w_state_nxt = ST_COMMIT;
                    w_start_nxt = 1'b1;
                    w_we_nxt    = (w_rd != '0);
                    w_waddr_nxt = w_rd;
                    w_wdata_nxt = sb.head_value;
                    w_cnt_nxt   = r_cnt + 1'b1;
                end
            end
            ST_COMMIT, ST_FLUSH: begin
                w_state_nxt = ST_SETTLE;
                if (sb.flush_req) begin
                    w_pend_nxt = 1'b1;
                    w_tag_nxt  = sb.flush_tag;
                end
            end
            ST_SETTLE: begin
                w_state_nxt = ST_IDLE;
                if (sb.flush_req) begin
                    w_pend_nxt = 1'b1;
                    w_tag_nxt  = sb.flush_tag;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign sb.start_head       = r_start;
    assign sb.committing_instr = r_start;
    assign sb.flushing_instr   = r_flush;
    assign sb.instr_to_flush   = r_itf;
    assign sb.rf_we            = r_we;
    assign sb.rf_waddr         = r_waddr;
    assign sb.rf_wdata         = r_wdata;
    assign sb.commit_count     = r_cnt;
    assign sb.busy             = r_busy;

`ifndef SYNTHESIS
    a_pop_flush_mutex: assert property (@(posedge clk) disable iff (!rst_n)
        !(r_start && r_flush));
    a_we_only_in_commit: assert property (@(posedge clk) disable iff (!rst_n)
        r_we |-> (r_state == ST_COMMIT));
    a_single_pop: assert property (@(posedge clk) disable iff (!rst_n)
        r_start |=> !r_start);
`endif

endmodule
`default_nettype wire

// File: tb/tb_commit_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_commit_unit
// Brief    : Directed vector bench for commit_unit (plus a narrow-counter copy).
// Revision : 1.0 - initial release
// ============================================================================
module tb_commit_unit;

    localparam logic [31:0] c_IA = 32'h0010_8093; // rd=1
    localparam logic [31:0] c_IB = 32'h0021_0113; // rd=2
    localparam logic [31:0] c_IC = 32'h0031_8193; // rd=3

    logic clk;
    logic rst_n;

    commit_unit_if #(.DATA_W(32), .REG_W(5), .CNT_W(32)) sb ();
    commit_unit_if #(.DATA_W(32), .REG_W(5), .CNT_W(3))  sb2 ();

    commit_unit #(.DATA_W(32), .REG_W(5), .CNT_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sb    (sb.slave)
    );

    // Second copy with a 3-bit counter to see the counter wrap.
    commit_unit #(.DATA_W(32), .REG_W(5), .CNT_W(3)) dut_w (
        .clk   (clk),
        .rst_n (rst_n),
        .sb    (sb2.slave)
    );

    assign sb2.is_empty   = sb.is_empty;
    assign sb2.head_ready = sb.head_ready;
    assign sb2.head_instr = sb.head_instr;
    assign sb2.head_value = sb.head_value;
    assign sb2.flush_req  = sb.flush_req;
    assign sb2.flush_tag  = sb.flush_tag;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        empty;
        logic        ready;
        logic [31:0] instr;
        logic [31:0] value;
        logic        freq;
        logic [31:0] ftag;
        logic        e_start;
        logic        e_flush;
        logic [31:0] e_itf;
        logic        e_we;
        logic [4:0]  e_waddr;
        logic [31:0] e_wdata;
        logic [31:0] e_cnt;
        logic        e_busy;
    } vec_t;

    vec_t vecs[$];
    int   checks;
    int   failures;
    int   cur;

    function automatic vec_t mk(
        input logic e, input logic r, input logic [31:0] ins, input logic [31:0] val,
        input logic fq, input logic [31:0] ft,
        input logic xs, input logic xf, input logic [31:0] xi, input logic xw,
        input logic [4:0] xa, input logic [31:0] xd, input logic [31:0] xc, input logic xb);
        vec_t v;
        v.empty = e;  v.ready = r;  v.instr = ins; v.value = val;
        v.freq = fq;  v.ftag = ft;
        v.e_start = xs; v.e_flush = xf; v.e_itf = xi; v.e_we = xw;
        v.e_waddr = xa; v.e_wdata = xd; v.e_cnt = xc; v.e_busy = xb;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d actual=0x%08h required=0x%08h", name, cur, act, exp);
        end
    endtask

    task automatic check_all(input vec_t e);
        chk("start_head",       {31'd0, sb.start_head},       {31'd0, e.e_start});
        chk("committing_instr", {31'd0, sb.committing_instr}, {31'd0, e.e_start});
        chk("flushing_instr",   {31'd0, sb.flushing_instr},   {31'd0, e.e_flush});
        chk("instr_to_flush",   sb.instr_to_flush,            e.e_itf);
        chk("rf_we",            {31'd0, sb.rf_we},            {31'd0, e.e_we});
        chk("rf_waddr",         {27'd0, sb.rf_waddr},         {27'd0, e.e_waddr});
        chk("rf_wdata",         sb.rf_wdata,                  e.e_wdata);
        chk("commit_count",     sb.commit_count,              e.e_cnt);
        chk("busy",             {31'd0, sb.busy},             {31'd0, e.e_busy});
        chk("count_wrap3",      {29'd0, sb2.commit_count},    {29'd0, e.e_cnt[2:0]});
    endtask

    task automatic drive(input vec_t v);
        sb.is_empty   = v.empty;
        sb.head_ready = v.ready;
        sb.head_instr = v.instr;
        sb.head_value = v.value;
        sb.flush_req  = v.freq;
        sb.flush_tag  = v.ftag;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    vec_t z;

    initial begin
        checks   = 0;
        failures = 0;
        cur      = -1;
        rst_n    = 1'b0;
        z = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(z);
        repeat (3) tick();
        check_all(z);
        rst_n = 1'b1;

        // empty scoreboard for ten cycles
        for (int i = 0; i < 10; i++) vecs.push_back(z);
        vecs.push_back(mk(1, 1, c_IA, 1,            0, 0, 0, 0, 0, 0, 0, 0,            0, 0));
        vecs.push_back(mk(0, 1, 32'h00A00293, 32'hDEADBEEF, 0, 0, 1, 0, 0, 1, 5, 32'hDEADBEEF, 1, 1));
        vecs.push_back(mk(0, 1, 32'h00A00293, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0,               0, 0, 0, 0, 0, 0, 0, 0,            1, 0));
        vecs.push_back(mk(0, 1, 32'h13, 32'h12345678, 0, 0, 1, 0, 0, 0, 0, 32'h12345678, 2, 1));
        vecs.push_back(mk(0, 0, 0, 0,               0, 0, 0, 0, 0, 0, 0, 0,            2, 1));
        vecs.push_back(mk(0, 0, 0, 0,               0, 0, 0, 0, 0, 0, 0, 0,            2, 0));
        // head_ready held across three entries
        vecs.push_back(mk(0, 1, c_IA, 1, 0, 0, 1, 0, 0, 1, 1, 1, 3, 1));
        vecs.push_back(mk(0, 1, c_IB, 2, 0, 0, 0, 0, 0, 0, 0, 0, 3, 1));
        vecs.push_back(mk(0, 1, c_IB, 2, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0));
        vecs.push_back(mk(0, 1, c_IB, 2, 0, 0, 1, 0, 0, 1, 2, 2, 4, 1));
        vecs.push_back(mk(0, 1, c_IC, 3, 0, 0, 0, 0, 0, 0, 0, 0, 4, 1));
        vecs.push_back(mk(0, 1, c_IC, 3, 0, 0, 0, 0, 0, 0, 0, 0, 4, 0));
        vecs.push_back(mk(0, 1, c_IC, 3, 0, 0, 1, 0, 0, 1, 3, 3, 5, 1));
        vecs.push_back(mk(1, 0, 0, 0,    0, 0, 0, 0, 0, 0, 0, 0, 5, 1));
        vecs.push_back(mk(1, 0, 0, 0,    0, 0, 0, 0, 0, 0, 0, 0, 5, 0));
        // flush and head ready together: flush wins
        vecs.push_back(mk(0, 1, c_IA, 1, 1, 7, 0, 1, 7, 0, 0, 0, 5, 1));
        vecs.push_back(mk(0, 1, c_IA, 1, 0, 0, 0, 0, 0, 0, 0, 0, 5, 1));
        vecs.push_back(mk(0, 1, c_IA, 1, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0));
        vecs.push_back(mk(0, 1, c_IA, 1, 0, 0, 1, 0, 0, 1, 1, 1, 6, 1));
        // flush during COMMIT is deferred until after SETTLE
        vecs.push_back(mk(1, 0, 0, 0, 1, 9, 0, 0, 0, 0, 0, 0, 6, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0, 6, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6, 0));
        // two deferred requests: newest tag wins, pending beats a ready head
        vecs.push_back(mk(0, 1, c_IB, 2, 0, 0,     1, 0, 0,     1, 2, 2, 7, 1));
        vecs.push_back(mk(1, 0, 0, 0,    1, 'hA,   0, 0, 0,     0, 0, 0, 7, 1));
        vecs.push_back(mk(1, 0, 0, 0,    1, 'hB,   0, 0, 0,     0, 0, 0, 7, 0));
        vecs.push_back(mk(0, 1, c_IC, 3, 0, 0,     0, 1, 'hB,   0, 0, 0, 7, 1));
        vecs.push_back(mk(0, 1, c_IC, 3, 0, 0,     0, 0, 0,     0, 0, 0, 7, 1));
        vecs.push_back(mk(0, 1, c_IC, 3, 0, 0,     0, 0, 0,     0, 0, 0, 7, 0));
        vecs.push_back(mk(0, 1, c_IC, 3, 0, 0,     1, 0, 0,     1, 3, 3, 8, 1));
        vecs.push_back(mk(1, 0, 0, 0,    0, 0,     0, 0, 0,     0, 0, 0, 8, 1));
        vecs.push_back(mk(1, 0, 0, 0,    0, 0,     0, 0, 0,     0, 0, 0, 8, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            cur = i;
            drive(vecs[i]);
            tick();
            check_all(vecs[i]);
        end

        // asynchronous reset in the middle of a COMMIT cycle
        cur = 100;
        drive(mk(0, 1, c_IA, 32'h55, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tick();
        chk("pre_reset_start", {31'd0, sb.start_head}, 32'd1);
        chk("pre_reset_we",    {31'd0, sb.rf_we},      32'd1);
        chk("pre_reset_cnt",   sb.commit_count,        32'd9);
        #2;
        rst_n = 1'b0;
        #1;
        cur = 101;
        check_all(z);
        drive(z);
        tick();
        rst_n = 1'b1;
        cur = 102;
        tick();
        check_all(z);
        cur = 103;
        drive(mk(0, 1, c_IA, 32'h55, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tick();
        check_all(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 32'h55, 1, 1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/commit_unit.md
# commit_unit

Retirement stage that drains the in-order scoreboard from its head. When the head entry is ready, it pops the entry, writes the result to the architectural register file and counts retired instructions. It also forwards branch-mispredict flush requests into the scoreboard. It sits between the scoreboard (head side) and the register-file write port, and is the consumer for everything the dispatch side pushes.

## Interface
- DATA_W, 32, width of instruction word and result value
- REG_W, 5, register index width; rd is taken from head_instr[11:7]
- CNT_W, 32, width of the retired-instruction counter

- clock  in  1  single clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately when 0
- is_empty  in  1  scoreboard holds no entries
- head_ready  in  1  scoreboard head entry has finished execution
- head_instr  in  DATA_W  instruction word at the scoreboard head
- head_value  in  DATA_W  result value of the head entry
- flush_req  in  1  one-cycle pulse from branch unit requesting a flush
- flush_tag  in  DATA_W  instruction identifier to flush from; valid with flush_req
- start_head  out  1  pop strobe to the scoreboard
- committing_instr  out  1  commit qualifier to the scoreboard; always equals start_head
- flushing_instr  out  1  flush strobe to the scoreboard
- instr_to_flush  out  DATA_W  flush identifier driven with flushing_instr
- rf_we  out  1  register-file write enable
- rf_waddr  out  REG_W  register-file write address
- rf_wdata  out  DATA_W  register-file write data
- commit_count  out  CNT_W  total instructions retired since reset
- busy  out  1  FSM not in IDLE

## Operation
- All outputs are registered.
- Reset value of every output and of all internal state is 0. The FSM resets to IDLE.
- FSM states are IDLE, COMMIT, FLUSH and SETTLE.
- IDLE: flush has priority over commit.
  - If flush_req is high or a flush is pending, go to FLUSH and latch the tag.
  - Otherwise, if is_empty=0 and head_ready=1, go to COMMIT and capture head_instr and head_value.
  - Otherwise, stay in IDLE.
- COMMIT: lasts exactly 1 cycle, then goes to SETTLE.
  - start_head=committing_instr=1.
  - rf_waddr=captured head_instr[11:7] and rf_wdata=captured head_value.
  - rf_we=1 only if rd!=0. rd=0 still pops and still counts.
  - commit_count increments by 1 and wraps modulo 2^CNT_W.
- FLUSH: lasts exactly 1 cycle, then goes to SETTLE; clears the pending flag.
  - flushing_instr=1 and instr_to_flush=latched tag.
  - No pop, no rf write, no count change.
- SETTLE: 1 cycle with all strobes 0, then goes to IDLE. This lets the scoreboard head, head_ready and is_empty update so a stale head is never committed twice.
- flush_req arriving in COMMIT, FLUSH or SETTLE sets the pending flag and latches flush_tag. The newest request overwrites the older one. The flush is serviced on the next IDLE.
- head_ready=1 with is_empty=1: no commit; is_empty wins.
- Asserting reset mid-operation immediately clears all strobes, the pending flag and commit_count. The FSM returns to IDLE with no partial writes.

## Timing
- Commit latency: 1 cycle from the edge that samples head ready in IDLE to start_head/rf_we high.
- Commit strobes are high for exactly 1 cycle.
- Commit throughput is one instruction per 3 cycles: IDLE, COMMIT, SETTLE.
- Flush latency: 1 cycle from flush_req sampled in IDLE to flushing_instr high. Worst case is 3 cycles if the request arrives during COMMIT.
- start_head and flushing_instr are never high in the same cycle.
- rf_we is never high outside COMMIT.
- commit_count updates on the same edge that raises start_head.
- busy=1 in COMMIT, FLUSH and SETTLE.

## Test plan
- Reset, then is_empty=1 for 10 cycles: all outputs stay 0 and commit_count=0.
- Head ready with head_instr=0x00A00293 (rd=5) and head_value=0xDEADBEEF: one cycle later start_head=committing_instr=rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF. After that cycle commit_count=1, then SETTLE, then IDLE.
- Head with rd=0 (head_instr=0x00000013): start_head=1, rf_we=0, commit_count increments.
- Head ready held high across 3 back-to-back entries: exactly 3 pops spaced 3 cycles apart, and commit_count=3.
- flush_req with tag 7 in the same cycle as head ready: flushing_instr=1 with instr_to_flush=7 and no pop. flush_req with tag 9 during COMMIT: pop completes, then flushing_instr=1 with instr_to_flush=9 after SETTLE.
- reset driven low during COMMIT: start_head and rf_we drop to 0 immediately (asynchronously), commit_count=0, and the FSM is in IDLE when reset is released.
